vga_timing_monitor: RTL

VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_if.sv | 9 +
 rtl/sync_edge_det.sv | 26 ++
 rtl/vga_timing_monitor.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster constants and types. The monitor's lock criteria and state
// encoding live here so that generators and checkers agree on the same geometry.
package vga_pkg;

  // Compact raster geometry: total clocks per line and total lines per frame.
  localparam int H_MAX = 10;
  localparam int V_MAX = 6;

  localparam int LOCK_FRAMES = 2;
  localparam int H_TIMEOUT   = 2 * H_MAX;
  localparam int V_TIMEOUT   = 2 * V_MAX;

  localparam int CNT_W   = 12;
  localparam int TOTAL_W = 11;
  localparam int ERR_W   = 8;
  localparam int GOOD_W  = 2;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [TOTAL_W-1:0] total_t;
  typedef logic [ERR_W-1:0]   err_cnt_t;
  typedef logic [GOOD_W-1:0]  good_cnt_t;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  // Measured lengths are reported on a narrower bus; clamp rather than wrap.
  function automatic total_t clamp_total(input cnt_t v);
    return (v > cnt_t'(2 ** TOTAL_W - 1)) ? '1 : v[TOTAL_W-1:0];
  endfunction

  function automatic err_cnt_t sat_inc(input err_cnt_t v);
    return (v == '1) ? v : v + err_cnt_t'(1);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing stream bundle: sync strobes plus display-enable.
interface vga_if;
  logic hsync;
  logic vsync;
  logic de;

  modport out (output hsync, vsync, de);
  modport in  (input  hsync, vsync, de);
endinterface

// File: rtl/sync_edge_det.sv
// Rising-edge detector for a sync strobe. The first cycle after reset only
// captures the level, so a strobe already high at reset release is not an edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;
  logic armed;

  // NOTE: state registers use non-blocking assignments and an async reset so every flop clears together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      sig_q <= sig;
      armed <= 1'b1;
    end
  end

  assign rise = armed & sig & ~sig_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// Watches hsync/vsync, measures line and frame lengths, and declares lock after
// consecutive clean frames; counts lock losses and flags each with a pulse.
module vga_timing_monitor
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  vga_if.in                  vga_in,
  output logic               locked,
  output logic               frame_err,
  output logic [TOTAL_W-1:0] h_total,
  output logic [TOTAL_W-1:0] v_total,
  output logic [ERR_W-1:0]   err_count
);

  localparam cnt_t      H_LEN     = cnt_t'(H_MAX);
  localparam cnt_t      V_LEN     = cnt_t'(V_MAX);
  localparam cnt_t      H_TO      = cnt_t'(H_TIMEOUT);
  localparam cnt_t      V_TO      = cnt_t'(V_TIMEOUT);
  localparam good_cnt_t LOCK_LAST = good_cnt_t'(LOCK_FRAMES - 1);

  logic       hs_rise;
  logic       vs_rise;
  cnt_t       hcnt;
  cnt_t       vlines;
  cnt_t       last_len;
  mon_state_t state;
  good_cnt_t  good_cnt;
  logic       line_bad;

  cnt_t line_len;
  cnt_t frame_len;
  cnt_t meas_line;
  logic timeout;
  logic line_err;
  logic frame_len_err;
  logic frame_bad;

  sync_edge_det u_hs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (vga_in.hsync),
    .rise (hs_rise)
  );

  sync_edge_det u_vs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (vga_in.vsync),
    .rise (vs_rise)
  );

  // A line ends on the hsync edge itself, so the edge cycle is part of its length.
  assign line_len      = hcnt + cnt_t'(1);
  assign frame_len     = vlines + cnt_t'(hs_rise);
  assign meas_line     = hs_rise ? line_len : last_len;
  assign timeout       = (hcnt == H_TO) || (vlines == V_TO);
  assign line_err      = hs_rise && (line_len != H_LEN);
  assign frame_len_err = (frame_len != V_LEN);
  assign frame_bad     = line_bad || line_err || frame_len_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      vlines   <= '0;
      last_len <= '0;
    end else begin
      if (timeout) begin
        hcnt   <= '0;
        vlines <= '0;
      end else begin
        hcnt <= hs_rise ? '0 : hcnt + cnt_t'(1);
        if (vs_rise)
          vlines <= '0;
        else if (hs_rise)
          vlines <= vlines + cnt_t'(1);
      end
      if (hs_rise)
        last_len <= line_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      line_bad  <= 1'b0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
      h_total   <= '0;
      v_total   <= '0;
      err_count <= '0;
    end else begin
      // NOTE: frame_err defaults low every cycle so any branch that sets it yields a single-cycle pulse.
      frame_err <= 1'b0;
      if (timeout) begin
        if (state == LOCKED) begin
          frame_err <= 1'b1;
          err_count <= sat_inc(err_count);
        end
        state    <= SEARCH;
        good_cnt <= '0;
        line_bad <= 1'b0;
        locked   <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            locked   <= 1'b0;
            good_cnt <= '0;
            if (vs_rise) begin
              state    <= MEASURE;
              line_bad <= 1'b0;
            end
          end

          MEASURE: begin
            if (vs_rise) begin
              h_total  <= clamp_total(meas_line);
              v_total  <= clamp_total(frame_len);
              line_bad <= 1'b0;
              if (frame_bad) begin
                good_cnt <= '0;
              end else if (good_cnt == LOCK_LAST) begin
                good_cnt <= good_cnt + good_cnt_t'(1);
                state    <= LOCKED;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_cnt + good_cnt_t'(1);
              end
            end else if (line_err) begin
              line_bad <= 1'b1;
            end
          end

          LOCKED: begin
            if (vs_rise) begin
              h_total <= clamp_total(meas_line);
              v_total <= clamp_total(frame_len);
            end
            // A bad line mid-frame taints the rest of that frame; at a frame
            // boundary the next frame starts clean.
            if (line_err || (vs_rise && frame_len_err)) begin
              frame_err <= 1'b1;
              err_count <= sat_inc(err_count);
              locked    <= 1'b0;
              state     <= MEASURE;
              good_cnt  <= '0;
              line_bad  <= ~vs_rise;
            end
          end

          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
